// File: rtl/tff_seq_pkg.sv
// Shared types and defaults for the toggle flip-flop burst sequencer.
// The state enum fixes the encoding used by the top-level FSM register.
package tff_seq_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tff_seq_state_e;

    // q expected after a burst: every pulse flips it, so only the length's LSB matters
    function automatic logic final_q_exp(input logic q0, input logic len_lsb);
        return q0 ^ len_lsb;
    endfunction

endpackage

// File: rtl/tff_seq_prescaler.sv
// Spacing counter for the toggle burst: counts 0..div and flags the terminal count.
// Clear wins over enable so a new burst always starts from zero.
module tff_seq_prescaler
    import tff_seq_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tc
);

    logic [DIV_W-1:0] cnt;

    assign tc = (cnt == div);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tff_toggle_sequencer.sv
// Burst generator for the downstream toggle flop: issues burst_len t pulses spaced
// div+1 cycles apart and checks the flop's final q against the expected parity.
module tff_toggle_sequencer
    import tff_seq_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] div,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             q_fb,
    output logic             t,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] pulse_cnt,
    output logic             parity_err
);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] RUN  = 2'(ST_RUN);
    localparam logic [1:0] DONE = 2'(ST_DONE);

    logic [1:0]       state;
    logic [DIV_W-1:0] div_q;
    logic [LEN_W-1:0] len_q;
    logic             q_start;
    logic             accept;
    logic             all_issued;
    logic             tc;

    assign accept     = (state == IDLE) && start;
    assign all_issued = (pulse_cnt == len_q);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

    tff_seq_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept),
        .en   (busy),
        .div  (div_q),
        .tc   (tc)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            t          <= 1'b0;
            pulse_cnt  <= '0;
            parity_err <= 1'b0;
            div_q      <= '0;
            len_q      <= '0;
            q_start    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    t <= 1'b0;
                    if (start) begin
                        div_q      <= div;
                        len_q      <= burst_len;
                        q_start    <= q_fb;
                        pulse_cnt  <= '0;
                        parity_err <= 1'b0;
                        state      <= (burst_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // abort outranks a pulse due now; the last pulse's cycle ends the burst
                    if (abort) begin
                        t     <= 1'b0;
                        state <= IDLE;
                    end else if (all_issued) begin
                        t     <= 1'b0;
                        state <= DONE;
                    end else if (tc) begin
                        t         <= 1'b1;
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end else begin
                        t <= 1'b0;
                    end
                end
                DONE: begin
                    t     <= 1'b0;
                    state <= IDLE;
                    if (q_fb != final_q_exp(q_start, len_q[0])) begin
                        parity_err <= 1'b1;
                    end
                end
                default: begin
                    t     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
